// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Synchroniser reset value that reads as "not pressed" for the given polarity.
  function automatic logic sync_rst_val(input int unsigned active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, qualification FSM and auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned STABLE_CNT = 24'hFF1000,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned REPEAT_DLY = 24'hFFFFFF,
  parameter int unsigned REPEAT_PER = 24'h7FFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam logic             SYNC_INIT   = sync_rst_val(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_DLY - 1);
  // Reload so the next strobe lands REPEAT_PER cycles later; clamped if PER exceeds DLY.
  localparam logic [CNT_W-1:0] REP_RELOAD  =
    (REPEAT_DLY >= REPEAT_PER) ? CNT_W'(REPEAT_DLY - REPEAT_PER) : '0;
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  if (STABLE_CNT < 1 || 64'(STABLE_CNT) >= (64'd1 << CNT_W)) begin : g_bad_stable
    $error("STABLE_CNT out of range");
  end
  if (REPEAT_DLY < 1 || 64'(REPEAT_DLY) >= (64'd1 << CNT_W)) begin : g_bad_dly
    $error("REPEAT_DLY out of range");
  end
  if (REPEAT_PER < 1 || 64'(REPEAT_PER) >= (64'd1 << CNT_W)) begin : g_bad_per
    $error("REPEAT_PER out of range");
  end

  logic             r_sync1, r_sync2;
  logic             w_act;
  db_state_e        r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_rcnt, w_rcnt_nx;
  logic             r_level, r_press, r_release, r_repeat;
  logic             w_level_nx, w_press_nx, w_release_nx, w_repeat_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= SYNC_INIT;
      r_sync2 <= SYNC_INIT;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_act = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_rcnt_nx    = r_rcnt;
    w_press_nx   = 1'b0;
    w_release_nx = 1'b0;
    w_repeat_nx  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nx = '0;
        if (w_act) begin
          if (STABLE_CNT == 1) begin
            w_state_nx = ST_HELD;
            w_press_nx = 1'b1;
            w_rcnt_nx  = '0;
          end else begin
            w_state_nx = ST_PRESS_WAIT;
            w_cnt_nx   = ONE;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_act) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nx = ST_HELD;
          w_press_nx = 1'b1;
          w_cnt_nx   = '0;
          w_rcnt_nx  = '0;
        end else begin
          w_cnt_nx = r_cnt + ONE;
        end
      end
      ST_HELD: begin
        if (!w_act) begin
          if (STABLE_CNT == 1) begin
            w_state_nx   = ST_IDLE;
            w_release_nx = 1'b1;
            w_cnt_nx     = '0;
            w_rcnt_nx    = '0;
          end else begin
            w_state_nx = ST_RELEASE_WAIT;
            w_cnt_nx   = ONE;
          end
        end else if (REPEAT_EN) begin
          if (r_rcnt == REP_LAST) begin
            w_repeat_nx = 1'b1;
            w_rcnt_nx   = REP_RELOAD;
          end else begin
            w_rcnt_nx = r_rcnt + ONE;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_act) begin
          w_state_nx = ST_HELD;
          w_cnt_nx   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nx   = ST_IDLE;
          w_release_nx = 1'b1;
          w_cnt_nx     = '0;
          w_rcnt_nx    = '0;
        end else begin
          w_cnt_nx = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
        w_rcnt_nx  = '0;
      end
    endcase
    w_level_nx = (w_state_nx == ST_HELD) || (w_state_nx == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_rcnt    <= w_rcnt_nx;
      r_level   <= w_level_nx;
      r_press   <= w_press_nx;
      r_release <= w_release_nx;
      r_repeat  <= w_repeat_nx;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: one independent debounce_channel per input bit.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned STABLE_CNT = 24'hFF1000,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned REPEAT_DLY = 24'hFFFFFF,
  parameter int unsigned REPEAT_PER = 24'h7FFFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_repeat
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT),
      .ACTIVE_LOW (ACTIVE_LOW),
      .REPEAT_EN  (REPEAT_EN),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (i[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_repeat  (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer with a run-length reference model.
module tb_button_debouncer;

  localparam int STABLE = 8;
  localparam int DLY    = 20;
  localparam int PER    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_raw = 4'b1111;
  logic [3:0] o_level, o_press, o_release, o_repeat;

  always #5 clk = ~clk;

  button_debouncer #(
    .N_CH       (4),
    .CNT_W      (24),
    .STABLE_CNT (STABLE),
    .ACTIVE_LOW (1),
    .REPEAT_EN  (1'b1),
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i         (i_raw),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_repeat  (o_repeat)
  );

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end
  endtask

  // Reference: a level flips once STABLE consecutive synchronised samples disagree
  // with it; repeats fire at DLY, DLY+PER, ... counted over uninterrupted held samples.
  initial begin : model
    logic [3:0] p1, p2, a, lvl, prev;
    int         run1[4], run0[4], held[4];
    exp_t       e;
    p1 = '0; p2 = '0; lvl = '0; prev = '0;
    for (int c = 0; c < 4; c++) begin run1[c] = 0; run0[c] = 0; held[c] = 0; end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        p1 = '0; p2 = '0; lvl = '0; prev = '0;
        for (int c = 0; c < 4; c++) begin run1[c] = 0; run0[c] = 0; held[c] = 0; end
        exp_q.delete();
      end else begin
        a  = p2;
        p2 = p1;
        p1 = ~i_raw;
        e  = '0;
        for (int c = 0; c < 4; c++) begin
          if (!lvl[c]) begin
            run1[c] = a[c] ? run1[c] + 1 : 0;
            if (run1[c] == STABLE) begin
              lvl[c] = 1'b1; e.press[c] = 1'b1; held[c] = 0; run0[c] = 0;
            end
          end else if (a[c]) begin
            if (prev[c]) begin
              held[c]++;
              if (held[c] == DLY || (held[c] > DLY && (held[c] - DLY) % PER == 0))
                e.rep[c] = 1'b1;
            end
            run0[c] = 0;
          end else begin
            run0[c]++;
            if (run0[c] == STABLE) begin
              lvl[c] = 1'b0; e.rel[c] = 1'b1; run1[c] = 0;
            end
          end
          prev[c] = a[c];
        end
        e.lvl = lvl;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_level", o_level, 4'b0000);
        chk("rst_press", o_press | o_release | o_repeat, 4'b0000);
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow t=%0t actual=empty required=entry", $time);
      end else begin
        e = exp_q.pop_front();
        chk("level",   o_level,   e.lvl);
        chk("press",   o_press,   e.press);
        chk("release", o_release, e.rel);
        chk("repeat",  o_repeat,  e.rep);
        chk("press_rel_overlap", o_press & o_release, 4'b0000);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int run[4];
    hold(3);
    #1 rst = 1'b0;
    hold(5);

    // clean press and release
    i_raw[0] = 1'b0; hold(30);
    i_raw[0] = 1'b1; hold(20);

    // bounce: 7-cycle presses never qualify
    for (int k = 0; k < 10; k++) begin
      i_raw[1] = 1'b0; hold(7);
      i_raw[1] = 1'b1; hold(1);
    end
    hold(20);

    // auto-repeat, plain hold then hold with a short dropout
    i_raw[2] = 1'b0; hold(60);
    i_raw[2] = 1'b1; hold(20);
    i_raw[2] = 1'b0; hold(35);
    i_raw[2] = 1'b1; hold(3);
    i_raw[2] = 1'b0; hold(25);
    i_raw[2] = 1'b1; hold(20);

    // simultaneous press, staggered release
    i_raw = 4'b0000; hold(30);
    i_raw[0] = 1'b1; hold(3);
    i_raw[1] = 1'b1; hold(4);
    i_raw[2] = 1'b1; hold(5);
    i_raw[3] = 1'b1; hold(20);

    // reset while held
    i_raw[0] = 1'b0; hold(15);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_level",   o_level,   4'b0000);
    chk("rst_async_press",   o_press,   4'b0000);
    chk("rst_async_release", o_release, 4'b0000);
    chk("rst_async_repeat",  o_repeat,  4'b0000);
    hold(2);
    #1 rst = 1'b0;
    hold(25);
    i_raw[0] = 1'b1; hold(20);

    // random run lengths straddling the qualification window
    for (int c = 0; c < 4; c++) run[c] = $urandom_range(1, 20);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        run[c]--;
        if (run[c] <= 0) begin
          i_raw[c] = ~i_raw[c];
          run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 60)
                                                : $urandom_range(1, 10);
        end
      end
    end

    i_raw = 4'b1111;
    hold(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
